// File: rtl/conv_pkg.sv
// Shared types and operand-layout helpers for the convolution host interface.
package conv_pkg;

  localparam int unsigned IMG_BYTES = 16;
  localparam int unsigned FLT_BYTES = 9;
  localparam int unsigned RES_BYTES = 4;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_RUN,
    ST_CAPTURE,
    ST_DRAIN
  } state_t;

  // Bit offset of image slot n (row-major, a11 at bit 0).
  function automatic logic [6:0] img_off(input logic [3:0] slot);
    return {slot, 3'b000};
  endfunction

  // Bit offset of filter slot n (row-major, b11 at bit 0).
  function automatic logic [6:0] flt_off(input logic [3:0] slot);
    return {slot, 3'b000};
  endfunction

endpackage

// File: rtl/single_array_host_if.sv
// Host front/back end for the single-PE convolution engine: gathers operands,
// runs one job on the engine, then streams the four result bytes back out.
module single_array_host_if #(
  parameter int unsigned RUN_CYCLES = 38,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [7:0]   in_data,
  output logic         in_ready,
  output logic [127:0] img_flat,
  output logic [71:0]  flt_flat,
  output logic         active_single,
  input  logic         done_single,
  input  logic [31:0]  res_flat,
  output logic         out_valid,
  output logic [7:0]   out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         err
);
  import conv_pkg::*;

  localparam int unsigned RW        = $clog2(TIMEOUT);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_CYCLES - 1);
  localparam logic [RW-1:0] TMO_LAST = RW'(TIMEOUT - 1);
  localparam logic [4:0] IMG_N      = 5'(IMG_BYTES);
  localparam logic [4:0] LOAD_LAST  = 5'(IMG_BYTES + FLT_BYTES - 1);
  localparam logic [1:0] DRAIN_LAST = 2'(RES_BYTES - 1);

  state_t        state, state_n;
  logic [4:0]    load_cnt;
  logic [RW-1:0] run_cnt;
  logic [1:0]    drain_cnt;
  logic [127:0]  img_q;
  logic [71:0]   flt_q;
  logic [31:0]   res_q;

  logic in_fire, out_fire, run_done, run_tmo;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign run_done = done_single && (run_cnt >= RUN_LAST);
  // A valid completion on the last allowed cycle wins over the timeout.
  assign run_tmo  = !run_done && (run_cnt == TMO_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_LOAD;
    else     state <= state_n;
  end

  // Next-state logic and decoded outputs.
  always_comb begin
    state_n       = state;
    in_ready      = 1'b0;
    active_single = 1'b0;
    out_valid     = 1'b0;
    err           = 1'b0;
    case (state)
      ST_LOAD: begin
        in_ready = 1'b1;
        if (in_fire && load_cnt == LOAD_LAST) state_n = ST_RUN;
      end
      ST_RUN: begin
        active_single = 1'b1;
        if (run_done) begin
          state_n = ST_CAPTURE;
        end else if (run_tmo) begin
          err     = 1'b1;
          state_n = ST_DRAIN;
        end
      end
      ST_CAPTURE: state_n = ST_DRAIN;
      ST_DRAIN: begin
        out_valid = 1'b1;
        if (out_fire && drain_cnt == DRAIN_LAST) state_n = ST_LOAD;
      end
      default: state_n = ST_LOAD;
    endcase
  end

  // Counters, operand registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      load_cnt  <= '0;
      run_cnt   <= '0;
      drain_cnt <= '0;
      img_q     <= '0;
      flt_q     <= '0;
      res_q     <= '0;
    end else begin
      case (state)
        ST_LOAD: begin
          run_cnt <= '0;
          if (in_fire) begin
            if (load_cnt < IMG_N) img_q[img_off(load_cnt[3:0]) +: 8] <= in_data;
            else                  flt_q[flt_off(4'(load_cnt - IMG_N)) +: 8] <= in_data;
            load_cnt <= (load_cnt == LOAD_LAST) ? '0 : load_cnt + 5'd1;
          end
        end
        ST_RUN: begin
          run_cnt <= run_cnt + RW'(1);
          if (run_tmo) res_q <= '0;
        end
        ST_CAPTURE: begin
          run_cnt <= '0;
          res_q   <= res_flat;
        end
        ST_DRAIN: begin
          run_cnt <= '0;
          if (out_fire) drain_cnt <= drain_cnt + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign img_flat = img_q;
  assign flt_flat = flt_q;
  assign out_data = out_valid ? res_q[{drain_cnt, 3'b000} +: 8] : 8'd0;
  assign busy     = !(state == ST_LOAD && load_cnt == 5'd0);

endmodule

// File: tb/tb_single_array_host_if.sv
// Directed bench for single_array_host_if with a behavioural engine model.
module tb_single_array_host_if;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic [7:0]   in_data;
  logic         in_ready;
  logic [127:0] img_flat;
  logic [71:0]  flt_flat;
  logic         active_single;
  logic         done_single;
  logic [31:0]  res_flat;
  logic         out_valid;
  logic [7:0]   out_data;
  logic         out_ready;
  logic         busy;
  logic         err;

  always #5 clk = ~clk;

  single_array_host_if #(.RUN_CYCLES(38), .TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .img_flat(img_flat), .flt_flat(flt_flat), .active_single(active_single),
    .done_single(done_single), .res_flat(res_flat), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .busy(busy), .err(err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Engine model: mode 0 = done once N active cycles seen, 1 = done stuck high, 2 = never done.
  int          mode = 0;
  int          eng_n = 38;
  int          act_cnt;
  logic [31:0] res_val = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) act_cnt <= 0;
    else     act_cnt <= active_single ? act_cnt + 1 : 0;
  end

  assign done_single = (mode == 1) ? 1'b1 :
                       (mode == 2) ? 1'b0 : (active_single && act_cnt >= eng_n - 1);
  assign res_flat = res_val;

  // Observers, sampled mid-cycle.
  int         act_total = 0, err_total = 0, err_at = -1, out_n = 0, in_acc = 0;
  int         rdy_in_drain = 0, stall_bad = 0;
  logic [7:0] out_log [0:63];
  logic       stalled_prev = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (rst) begin
      stalled_prev = 1'b0;
    end else begin
      if (active_single) act_total++;
      if (err) begin err_total++; err_at = act_cnt; end
      if (in_valid && in_ready) in_acc++;
      if (out_valid && in_ready) rdy_in_drain++;
      if (stalled_prev && (!out_valid || out_data !== prev_data)) stall_bad++;
      if (out_valid && out_ready) begin
        out_log[out_n % 64] = out_data;
        out_n++;
      end
      stalled_prev = out_valid && !out_ready;
      prev_data    = out_data;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_job(input logic [7:0] base, input bit gap, input int count);
    for (int i = 0; i < count; i++) begin
      in_data  = base + 8'(i);
      in_valid = 1'b1;
      tick();
      if (gap && i != count - 1) begin
        in_valid = 1'b0;
        tick();
        tick();
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_load(input bit toggle, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (in_ready) begin ok = 1'b1; break; end
      if (toggle) out_ready = ~out_ready;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick(); tick();
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    n_cmp++; if (active_single !== 1'b0) begin n_bad++; $display("FAIL rst_active: got %b want 0", active_single); end
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'd0) begin n_bad++; $display("FAIL rst_out: got v=%b d=%h want 0/00", out_valid, out_data); end
    n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL rst_busy_err: got %b/%b want 0/0", busy, err); end
    n_cmp++; if (img_flat !== '0 || flt_flat !== '0) begin n_bad++; $display("FAIL rst_operands: got %h %h want 0", img_flat, flt_flat); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int a0, o0, e0; bit ok;
    logic [127:0] exp_img; logic [71:0] exp_flt; logic [7:0] b;
    mode = 0; res_val = 32'h44332211;
    a0 = act_total; o0 = out_n; e0 = err_total;
    load_job(8'd1, 1'b0, 25);
    n_cmp++; if (active_single !== 1'b1) begin n_bad++; $display("FAIL basic_latency: active got %b want 1", active_single); end
    n_cmp++; if (in_ready !== 1'b0 || busy !== 1'b1) begin n_bad++; $display("FAIL basic_run_flags: rdy=%b busy=%b want 0/1", in_ready, busy); end
    for (int k = 0; k < 16; k++) exp_img[8*k +: 8] = 8'(k + 1);
    for (int k = 0; k < 9; k++)  exp_flt[8*k +: 8] = 8'(k + 17);
    n_cmp++; if (img_flat[7:0] !== 8'd1 || img_flat[127:120] !== 8'd16) begin n_bad++; $display("FAIL basic_img_ends: got %0d,%0d want 1,16", img_flat[7:0], img_flat[127:120]); end
    n_cmp++; if (flt_flat[7:0] !== 8'd17 || flt_flat[71:64] !== 8'd25) begin n_bad++; $display("FAIL basic_flt_ends: got %0d,%0d want 17,25", flt_flat[7:0], flt_flat[71:64]); end
    n_cmp++; if (img_flat !== exp_img) begin n_bad++; $display("FAIL basic_img: got %h want %h", img_flat, exp_img); end
    n_cmp++; if (flt_flat !== exp_flt) begin n_bad++; $display("FAIL basic_flt: got %h want %h", flt_flat, exp_flt); end
    wait_load(1'b0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL basic_timeout: got no return to LOAD want return"); end
    n_cmp++; if (act_total - a0 != 38) begin n_bad++; $display("FAIL basic_active_len: got %0d want 38", act_total - a0); end
    n_cmp++; if (out_n - o0 != 4) begin n_bad++; $display("FAIL basic_out_count: got %0d want 4", out_n - o0); end
    for (int k = 0; k < 4; k++) begin
      b = res_val[8*k +: 8];
      n_cmp++; if (out_log[(o0 + k) % 64] !== b) begin n_bad++; $display("FAIL basic_out%0d: got %h want %h", k, out_log[(o0 + k) % 64], b); end
    end
    n_cmp++; if (err_total != e0) begin n_bad++; $display("FAIL basic_err: got %0d pulses want 0", err_total - e0); end
    n_cmp++; if (busy !== 1'b0 || img_flat !== exp_img) begin n_bad++; $display("FAIL basic_idle: busy=%b img=%h want 0 and operands held", busy, img_flat); end
  endtask

  task automatic test_stall();
    int o0, s0; bit ok; logic [7:0] b;
    mode = 0; res_val = 32'h44332211;
    o0 = out_n; s0 = stall_bad;
    load_job(8'd1, 1'b0, 25);
    wait_load(1'b1, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stall_timeout: got no return to LOAD want return"); end
    n_cmp++; if (out_n - o0 != 4) begin n_bad++; $display("FAIL stall_count: got %0d want 4", out_n - o0); end
    n_cmp++; if (stall_bad != s0) begin n_bad++; $display("FAIL stall_stable: got %0d changes want 0", stall_bad - s0); end
    for (int k = 0; k < 4; k++) begin
      b = res_val[8*k +: 8];
      n_cmp++; if (out_log[(o0 + k) % 64] !== b) begin n_bad++; $display("FAIL stall_out%0d: got %h want %h", k, out_log[(o0 + k) % 64], b); end
    end
  endtask

  task automatic test_done_stuck();
    int a0, o0; bit ok; logic [7:0] b;
    mode = 1; res_val = 32'hA1B2C3D4;
    a0 = act_total; o0 = out_n;
    load_job(8'd7, 1'b0, 25);
    wait_load(1'b0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL stuck_timeout: got no return to LOAD want return"); end
    n_cmp++; if (act_total - a0 != 38) begin n_bad++; $display("FAIL stuck_active_len: got %0d want 38", act_total - a0); end
    for (int k = 0; k < 4; k++) begin
      b = res_val[8*k +: 8];
      n_cmp++; if (out_log[(o0 + k) % 64] !== b) begin n_bad++; $display("FAIL stuck_out%0d: got %h want %h", k, out_log[(o0 + k) % 64], b); end
    end
    mode = 0;
  endtask

  task automatic test_timeout();
    int a0, o0, e0; bit ok;
    mode = 2; res_val = 32'hDEADBEEF;
    a0 = act_total; o0 = out_n; e0 = err_total;
    load_job(8'd3, 1'b0, 25);
    wait_load(1'b0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL tmo_timeout: got no return to LOAD want return"); end
    n_cmp++; if (err_total - e0 != 1) begin n_bad++; $display("FAIL tmo_err_count: got %0d want 1", err_total - e0); end
    n_cmp++; if (err_at != 63) begin n_bad++; $display("FAIL tmo_err_at: got %0d want 63", err_at); end
    n_cmp++; if (act_total - a0 != 64) begin n_bad++; $display("FAIL tmo_active_len: got %0d want 64", act_total - a0); end
    n_cmp++; if (out_n - o0 != 4) begin n_bad++; $display("FAIL tmo_out_count: got %0d want 4", out_n - o0); end
    for (int k = 0; k < 4; k++) begin
      n_cmp++; if (out_log[(o0 + k) % 64] !== 8'h00) begin n_bad++; $display("FAIL tmo_out%0d: got %h want 00", k, out_log[(o0 + k) % 64]); end
    end
    mode = 0;
  endtask

  task automatic test_reset_mid();
    int a0, o0, c; bit ok; logic [7:0] b;
    mode = 0;
    load_job(8'h40, 1'b0, 10);
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL mid_load_busy: got %b want 1", busy); end
    rst = 1'b1; #1;
    n_cmp++; if (busy !== 1'b0 || in_ready !== 1'b1 || active_single !== 1'b0 || out_valid !== 1'b0 || err !== 1'b0)
      begin n_bad++; $display("FAIL mid_load_rst: busy=%b rdy=%b act=%b ov=%b err=%b want 0 1 0 0 0", busy, in_ready, active_single, out_valid, err); end
    n_cmp++; if (img_flat !== '0) begin n_bad++; $display("FAIL mid_load_img: got %h want 0", img_flat); end
    tick(); rst = 1'b0; tick();

    res_val = 32'h0F1E2D3C; a0 = act_total; o0 = out_n;
    load_job(8'h60, 1'b0, 25);
    n_cmp++; if (img_flat[7:0] !== 8'h60 || flt_flat[71:64] !== 8'h78) begin n_bad++; $display("FAIL mid_job1_ops: got %h,%h want 60,78", img_flat[7:0], flt_flat[71:64]); end
    wait_load(1'b0, ok);
    n_cmp++; if (!ok || act_total - a0 != 38) begin n_bad++; $display("FAIL mid_job1_run: ok=%b active=%0d want 1/38", ok, act_total - a0); end
    for (int k = 0; k < 4; k++) begin
      b = res_val[8*k +: 8];
      n_cmp++; if (out_log[(o0 + k) % 64] !== b) begin n_bad++; $display("FAIL mid_job1_out%0d: got %h want %h", k, out_log[(o0 + k) % 64], b); end
    end

    res_val = 32'h99887766; o0 = out_n;
    load_job(8'h80, 1'b0, 25);
    c = 0;
    while (!(out_valid && out_n - o0 >= 1) && c < 200) begin tick(); c++; end
    n_cmp++; if (c >= 200) begin n_bad++; $display("FAIL mid_drain_reach: got no drain want drain"); end
    rst = 1'b1; #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 8'd0 || busy !== 1'b0 || in_ready !== 1'b1)
      begin n_bad++; $display("FAIL mid_drain_rst: ov=%b od=%h busy=%b rdy=%b want 0 00 0 1", out_valid, out_data, busy, in_ready); end
    n_cmp++; if (flt_flat !== '0) begin n_bad++; $display("FAIL mid_drain_flt: got %h want 0", flt_flat); end
    tick(); rst = 1'b0; tick();

    res_val = 32'h04030201; a0 = act_total; o0 = out_n;
    load_job(8'hA0, 1'b0, 25);
    wait_load(1'b0, ok);
    n_cmp++; if (!ok || act_total - a0 != 38 || out_n - o0 != 4) begin n_bad++; $display("FAIL mid_job2_run: ok=%b active=%0d outs=%0d want 1/38/4", ok, act_total - a0, out_n - o0); end
    for (int k = 0; k < 4; k++) begin
      b = res_val[8*k +: 8];
      n_cmp++; if (out_log[(o0 + k) % 64] !== b) begin n_bad++; $display("FAIL mid_job2_out%0d: got %h want %h", k, out_log[(o0 + k) % 64], b); end
    end
  endtask

  task automatic test_gaps();
    int i0, r0, o0; bit ok; logic [7:0] b;
    mode = 0; res_val = 32'h88776655;
    i0 = in_acc; r0 = rdy_in_drain; o0 = out_n;
    load_job(8'hC0, 1'b1, 25);
    in_valid = 1'b1; in_data = 8'hEE;
    wait_load(1'b0, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL gaps_timeout: got no return to LOAD want return"); end
    n_cmp++; if (in_acc - i0 != 25) begin n_bad++; $display("FAIL gaps_accepts: got %0d want 25", in_acc - i0); end
    n_cmp++; if (rdy_in_drain != r0) begin n_bad++; $display("FAIL gaps_ready_in_drain: got %0d cycles want 0", rdy_in_drain - r0); end
    n_cmp++; if (img_flat[127:120] !== 8'hCF || flt_flat[7:0] !== 8'hD0 || flt_flat[71:64] !== 8'hD8)
      begin n_bad++; $display("FAIL gaps_ops: got %h,%h,%h want CF,D0,D8", img_flat[127:120], flt_flat[7:0], flt_flat[71:64]); end
    for (int k = 0; k < 4; k++) begin
      b = res_val[8*k +: 8];
      n_cmp++; if (out_log[(o0 + k) % 64] !== b) begin n_bad++; $display("FAIL gaps_out%0d: got %h want %h", k, out_log[(o0 + k) % 64], b); end
    end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL gaps_idle: busy got %b want 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_done_stuck();
    test_timeout();
    test_reset_mid();
    test_gaps();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: got no completion want completion");
    $fatal(1, "watchdog");
  end

endmodule
